// File: rtl/defines.sv
// Global width macros shared by the memory-side blocks.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 16
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache with 4-word lines.
// Optional CACHE_STATS_EN adds load hit/miss counters.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 16
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module cache_controller #(
  parameter int INDEX_BITS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [`ADDRESS_LEN-1:0] cpu_addr,
  input  logic [`WORD_LEN-1:0]    cpu_wdata,
  input  logic                    cpu_rd,
  input  logic                    cpu_wr,
  output logic [`WORD_LEN-1:0]    cpu_rdata,
  output logic                    cpu_ready,
  output logic [`ADDRESS_LEN-1:0] mem_addr,
  output logic [`WORD_LEN-1:0]    mem_wdata,
  output logic                    mem_rd,
  output logic                    mem_wr,
  input  logic [4*`WORD_LEN-1:0]  mem_rdata,
  input  logic                    mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = `ADDRESS_LEN - INDEX_BITS - 2;
  localparam int WW    = `WORD_LEN;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_load;
  logic [LINES-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [WW-1:0]         r_data [LINES][4];

  logic [1:0]            w_off;
  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic [WW-1:0]         w_word;

  assign w_off  = cpu_addr[1:0];
  assign w_idx  = cpu_addr[INDEX_BITS+1:2];
  assign w_tag  = cpu_addr[`ADDRESS_LEN-1:INDEX_BITS+2];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_word = r_data[w_idx][w_off];

  always_comb begin
    w_next    = r_state;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: begin
        if (cpu_wr) begin
          w_next = WRITE;
        end else if (cpu_rd) begin
          if (w_hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = w_word;
          end else begin
            w_next = FILL;
          end
        end
      end
      FILL: begin
        mem_rd   = 1'b1;
        mem_addr = {cpu_addr[`ADDRESS_LEN-1:2], 2'b00};
        if (mem_ack) w_next = RESP;
      end
      WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (mem_ack) w_next = RESP;
      end
      RESP: begin
        cpu_ready = 1'b1;
        // The line was just filled, so the array already holds the word.
        if (r_load) cpu_rdata = w_word;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_load  <= 1'b0;
      r_valid <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) r_load <= (w_next == FILL);
      if (r_state == FILL && mem_ack) r_valid[w_idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; valid bits alone decide hits.
  always_ff @(posedge clk) begin
    if (!rst && r_state == FILL && mem_ack) begin
      r_tag[w_idx] <= w_tag;
      for (int k = 0; k < 4; k++) r_data[w_idx][k] <= mem_rdata[(3-k)*WW +: WW];
    end
    if (!rst && r_state == WRITE && mem_ack && w_hit) begin
      r_data[w_idx][w_off] <= cpu_wdata;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (r_state == IDLE && cpu_rd && !cpu_wr && w_hit) hit_count <= hit_count + 32'd1;
      if (r_state == FILL && mem_ack && r_load) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with an inline memory responder and result scoreboard.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 16
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module tb_cache_controller;
  localparam int IB = 10;
  localparam int AW = `ADDRESS_LEN;
  localparam int WW = `WORD_LEN;

  logic          clk;
  logic          rst;
  logic [AW-1:0] cpu_addr;
  logic [WW-1:0] cpu_wdata;
  logic          cpu_rd;
  logic          cpu_wr;
  logic [WW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic [4*WW-1:0] mem_rdata;
  logic          mem_ack;
`ifdef CACHE_STATS_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  cache_controller #(.INDEX_BITS(IB)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WW-1:0] sb[$];
  logic [WW-1:0] mem_w [logic [AW-1:0]];

  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
    if (mem_w.exists(a)) return mem_w[a];
    return WW'(32'hA5C3_0000) ^ WW'(a);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [AW-1:0] a, input bit exp_hit, input string tag);
    logic [AW-1:0] base;
    int  ackc;
    bit  done, sawrd;
    base = {a[AW-1:2], 2'b00};
    @(negedge clk);
    cpu_addr = a; cpu_rd = 1'b1; cpu_wr = 1'b0;
    sb.push_back(mem_word(a));
    ackc = 0; done = 0; sawrd = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      chk({tag, "_excl"}, mem_rd & mem_wr, 0);
      if (mem_rd) begin
        if (!sawrd) chk({tag, "_maddr"}, mem_addr, base);
        sawrd = 1; ackc++;
        if (ackc == 3) begin
          mem_ack   = 1'b1;
          mem_rdata = {mem_word(base), mem_word(base + 1), mem_word(base + 2), mem_word(base + 3)};
        end
      end
      if (cpu_ready) begin
        chk({tag, "_path"}, {sawrd, c == 0}, exp_hit ? 2'b01 : 2'b10);
        chk({tag, "_data"}, cpu_rdata, sb.pop_front());
        done = 1;
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    chk({tag, "_ready"}, done, 1);
    cpu_rd = 1'b0;
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [WW-1:0] d, input bit both,
                          input string tag);
    int ackc;
    bit done, sawwr;
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1; cpu_rd = both;
    sb.push_back('0);
    ackc = 0; done = 0; sawwr = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      chk({tag, "_excl"}, mem_rd & mem_wr, 0);
      if (mem_wr) begin
        if (!sawwr) chk({tag, "_mwrite"}, {mem_addr, mem_wdata}, {a, d});
        sawwr = 1; ackc++;
        if (ackc == 2) mem_ack = 1'b1;
      end
      if (cpu_ready) begin
        chk({tag, "_wpath"}, sawwr, 1);
        chk({tag, "_rdata0"}, cpu_rdata, sb.pop_front());
        done = 1;
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    chk({tag, "_ready"}, done, 1);
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    mem_w[a] = d;
  endtask

  initial begin
    bit saw;
    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_ctl", {cpu_ready, mem_rd, mem_wr}, 0);
    chk("reset_data", {cpu_rdata, mem_addr, mem_wdata}, 0);
`ifdef CACHE_STATS_EN
    chk("reset_stats", {hit_count, miss_count}, 0);
`endif
    rst = 1'b0;

    do_load(16'h0005, 0, "fill_b");
    do_load(16'h0006, 1, "hit_c");
    do_store(16'h0007, 32'h0000_1234, 0, "store_hit");
    do_load(16'h0007, 1, "hit_stored");
    do_load(16'h0004 + (1 << (IB + 2)), 0, "alias_fill");
    do_load(16'h0004, 0, "alias_evict");
`ifdef CACHE_STATS_EN
    chk("stats", {hit_count, miss_count}, {32'd2, 32'd3});
`endif
    do_load(16'h0007, 1, "refill_stored");
    do_store(16'h0006, 32'hBEEF_0001, 1, "store_prio");
    do_load(16'h0006, 1, "hit_prio");
    do_store(16'h0300, 32'h0000_0777, 0, "store_miss");
    do_load(16'h0300, 0, "no_alloc");

    // Abandon a refill with reset, then show the stray ack is ignored.
    @(negedge clk);
    cpu_addr = 16'h0040; cpu_rd = 1'b1;
    saw = 0;
    for (int c = 0; c < 10 && !saw; c++) begin
      #1;
      if (mem_rd) saw = 1;
      @(negedge clk);
    end
    chk("rst_fill_seen", saw, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cpu_rd = 1'b0;
    #1;
    chk("rst_abandon", {mem_rd, mem_wr, cpu_ready}, 0);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = {4{32'hDEAD_DEAD}};
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("rst_stray_ack", {mem_rd, mem_wr, cpu_ready, cpu_rdata}, 0);
    do_load(16'h0040, 0, "rst_reload");
    do_load(16'h0005, 0, "rst_cleared");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
